// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file write-back constants
package regfile_pkg;
    localparam int ADDR_W     = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_REQ    = 3;
    localparam int NUM_REGS   = 32;
    localparam int REQ_ALU    = 0;
    localparam int REQ_LOAD   = 1;
    localparam int REQ_MULDIV = 2;
endpackage

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: one-hot write-back grant; round-robin under WB_ROUND_ROBIN_EN, else lowest index wins
module wb_rr_arbiter
    import regfile_pkg::*;
#(
    parameter int N = NUM_REQ
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req_valid,
    output logic [N-1:0] grant
);
`ifdef WB_ROUND_ROBIN_EN
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    logic [PW-1:0] ptr_q, ptr_d, idx;
    // Walk from the farthest candidate back to the pointer so the nearest valid wins.
    always_comb begin
        grant = '0;
        ptr_d = ptr_q;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = PW'((int'(ptr_q) + k) % N);
            if (req_valid[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                ptr_d      = PW'((int'(ptr_q) + k + 1) % N);
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end
`else
    logic unused_clk_rst;
    assign unused_clk_rst = &{1'b0, clk, rst_n};
    always_comb begin
        grant = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_valid[k]) begin
                grant    = '0;
                grant[k] = 1'b1;
            end
        end
    end
`endif
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: arbitrated register-file write port plus busy scoreboard; WB_ROUND_ROBIN_EN selects round-robin
module regfile_wb_arbiter
    import regfile_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic                      alloc_en,
    input  logic [ADDR_W-1:0]         alloc_addr,
    input  logic                      flush,
    output logic                      wr_en,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [DATA_W-1:0]         wr_data,
    output logic [NUM_REGS-1:0]       busy
);
    logic [NUM_REQ-1:0]  grant;
    logic [ADDR_W-1:0]   sel_addr, wr_addr_d, wr_addr_q;
    logic [DATA_W-1:0]   sel_data, wr_data_d, wr_data_q;
    logic                wr_en_d, wr_en_q;
    logic [NUM_REGS-1:0] busy_d, busy_q;

    wb_rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .grant     (grant)
    );

    assign req_ready = grant;
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign busy      = busy_q;

    // Allocation is applied last so a same-edge set beats both the write-back clear and flush.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
        wr_en_d   = |grant && sel_addr != '0;
        wr_addr_d = |grant ? sel_addr : wr_addr_q;
        wr_data_d = |grant ? sel_data : wr_data_q;
        busy_d    = flush ? '0 : busy_q;
        if (wr_en_q)  busy_d[wr_addr_q]  = 1'b0;
        if (alloc_en) busy_d[alloc_addr] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= '0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: randomized and directed bench against a behavioural write-back model
module tb_regfile_wb_arbiter;
    import regfile_pkg::*;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic [NUM_REQ-1:0]        req_valid, req_ready;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic                      alloc_en, flush, wr_en;
    logic [ADDR_W-1:0]         alloc_addr, wr_addr;
    logic [DATA_W-1:0]         wr_data;
    logic [NUM_REGS-1:0]       busy;

    int n_checks = 0;
    int n_fail   = 0;

    bit        m_wr_en;
    bit [4:0]  m_wr_addr;
    bit [31:0] m_wr_data, m_busy;
    int        m_ptr;
    logic [NUM_REQ-1:0] last_ready;

    regfile_wb_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .flush      (flush),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic int pick(input logic [NUM_REQ-1:0] v);
`ifdef WB_ROUND_ROBIN_EN
        for (int k = 0; k < NUM_REQ; k++)
            if (v[(m_ptr + k) % NUM_REQ]) return (m_ptr + k) % NUM_REQ;
`else
        for (int k = 0; k < NUM_REQ; k++)
            if (v[k]) return k;
`endif
        return -1;
    endfunction

    task automatic model_reset();
        m_wr_en = 0; m_wr_addr = 0; m_wr_data = 0; m_busy = 0; m_ptr = 0;
    endtask

    task automatic idle();
        req_valid = '0; req_addr = '0; req_data = '0;
        alloc_en = 0; alloc_addr = '0; flush = 0;
    endtask

    task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
        req_valid[i] = 1'b1;
        req_addr[i*ADDR_W +: ADDR_W] = a;
        req_data[i*DATA_W +: DATA_W] = d;
    endtask

    // One clock cycle: check ready mid-cycle, advance model, check registered outputs after the edge.
    task automatic step(input string name);
        int g;
        logic [NUM_REQ-1:0] exp_rdy;
        bit [31:0] nb;
        @(negedge clk);
        g = pick(req_valid);
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        last_ready = req_ready;
        n_checks++;
        if (req_ready !== exp_rdy) begin
            n_fail++;
            $display("FAIL %s req_ready: got %b expected %b", name, req_ready, exp_rdy);
        end
        nb = flush ? 32'd0 : m_busy;
        if (m_wr_en) nb[m_wr_addr] = 1'b0;
        if (alloc_en && alloc_addr != 0) nb[alloc_addr] = 1'b1;
        if (g >= 0) begin
            m_wr_addr = req_addr[g*ADDR_W +: ADDR_W];
            m_wr_data = req_data[g*DATA_W +: DATA_W];
            m_wr_en   = m_wr_addr != 0;
            m_ptr     = (g + 1) % NUM_REQ;
        end else m_wr_en = 0;
        m_busy = nb;
        @(posedge clk);
        #1;
        n_checks++;
        if (wr_en !== m_wr_en || wr_addr !== m_wr_addr || wr_data !== m_wr_data) begin
            n_fail++;
            $display("FAIL %s wr: got en=%b a=%0d d=%h expected en=%b a=%0d d=%h",
                     name, wr_en, wr_addr, wr_data, m_wr_en, m_wr_addr, m_wr_data);
        end
        n_checks++;
        if (busy !== m_busy) begin
            n_fail++;
            $display("FAIL %s busy: got %h expected %h", name, busy, m_busy);
        end
    endtask

    task automatic apply_reset();
        idle();
        rst_n = 0;
        model_reset();
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0;
        #3;
        n_checks++;
        if (wr_en !== 1'b0 || busy !== 32'd0 || req_ready !== 3'b000 || wr_addr !== 5'd0 || wr_data !== 32'd0) begin
            n_fail++;
            $display("FAIL reset: got en=%b busy=%h rdy=%b a=%0d d=%h expected all zero",
                     wr_en, busy, req_ready, wr_addr, wr_data);
        end
        apply_reset();
        step("idle");
        step("idle2");
    endtask

    task automatic test_single();
        idle(); alloc_en = 1; alloc_addr = 5;
        step("alloc5");
        idle(); set_req(REQ_ALU, 5, 32'hDEADBEEF);
        step("alu_wr");
        n_checks++;
        if (last_ready !== 3'b001 || wr_en !== 1'b1 || wr_addr !== 5'd5 || wr_data !== 32'hDEADBEEF || busy[5] !== 1'b1) begin
            n_fail++;
            $display("FAIL single: got rdy=%b en=%b a=%0d d=%h b5=%b expected 001 1 5 deadbeef 1",
                     last_ready, wr_en, wr_addr, wr_data, busy[5]);
        end
        idle();
        step("alu_commit");
        n_checks++;
        if (busy[5] !== 1'b0) begin
            n_fail++;
            $display("FAIL single_busy_clear: got %b expected 0", busy[5]);
        end
    endtask

    task automatic test_arb();
        int exp_g[6];
        apply_reset();
        idle();
        set_req(REQ_ALU, 1, 32'h11);
        set_req(REQ_LOAD, 2, 32'h22);
        set_req(REQ_MULDIV, 3, 32'h33);
        for (int i = 0; i < 6; i++) begin
`ifdef WB_ROUND_ROBIN_EN
            exp_g[i] = i % 3;
`else
            exp_g[i] = 0;
`endif
            step("arb");
            n_checks++;
            if (last_ready !== (3'b001 << exp_g[i])) begin
                n_fail++;
                $display("FAIL arb_seq[%0d]: got %b expected %b", i, last_ready, 3'b001 << exp_g[i]);
            end
        end
    endtask

    task automatic test_r0();
        idle(); set_req(REQ_LOAD, 0, 32'h12345678);
        step("r0");
        n_checks++;
        if (last_ready !== 3'b010 || wr_en !== 1'b0 || busy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL r0: got rdy=%b en=%b b0=%b expected 010 0 0", last_ready, wr_en, busy[0]);
        end
    endtask

    task automatic test_collision();
        idle(); alloc_en = 1; alloc_addr = 9;
        step("alloc9");
        idle(); set_req(REQ_MULDIV, 9, 32'hCAFE0009);
        step("wr9");
        idle(); alloc_en = 1; alloc_addr = 9;
        step("realloc9");
        n_checks++;
        if (busy[9] !== 1'b1) begin
            n_fail++;
            $display("FAIL collision_busy9: got %b expected 1", busy[9]);
        end
    endtask

    task automatic test_flush();
        idle(); alloc_en = 1; alloc_addr = 3;
        step("alloc3");
        idle(); alloc_en = 1; alloc_addr = 7;
        step("alloc7");
        idle(); flush = 1; alloc_en = 1; alloc_addr = 7;
        set_req(REQ_MULDIV, 20, 32'hF00D0020);
        step("flush");
        n_checks++;
        if (busy !== 32'h0000_0080 || wr_en !== 1'b1 || wr_addr !== 5'd20) begin
            n_fail++;
            $display("FAIL flush: got busy=%h en=%b a=%0d expected 00000080 1 20", busy, wr_en, wr_addr);
        end
    endtask

    task automatic test_async_reset();
        idle(); alloc_en = 1; alloc_addr = 4; set_req(REQ_ALU, 4, 32'hA5A5A5A5);
        step("pre_rst");
        idle(); set_req(REQ_LOAD, 6, 32'h66);
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        n_checks++;
        if (wr_en !== 1'b0 || wr_addr !== 5'd0 || wr_data !== 32'd0 || busy !== 32'd0) begin
            n_fail++;
            $display("FAIL async_reset: got en=%b a=%0d d=%h busy=%h expected zeros", wr_en, wr_addr, wr_data, busy);
        end
        model_reset();
        @(posedge clk);
        #1 rst_n = 1;
        idle();
        step("post_rst");
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            idle();
            for (int i = 0; i < NUM_REQ; i++)
                if ($urandom_range(0, 1) == 1) set_req(i, 5'($urandom_range(0, 31)), $urandom);
            alloc_en   = $urandom_range(0, 1) == 1;
            alloc_addr = 5'($urandom_range(0, 31));
            flush      = $urandom_range(0, 15) == 0;
            step("random");
        end
    endtask

    initial begin
        idle();
        model_reset();
        last_ready = '0;
        test_reset();
        test_single();
        test_arb();
        test_r0();
        test_collision();
        test_flush();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
